// File: rtl/pu_msp430_irq_pkg.sv
// Shared types and constants for the MSP430 interrupt scheduler.
// Vector numbers index the table at VEC_BASE; 15 is reserved for reset.
package pu_msp430_irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } irq_state_t;

  localparam logic [3:0]  NMI_VEC  = 4'd14;
  localparam logic [3:0]  RST_VEC  = 4'd15;
  localparam logic [15:0] VEC_BASE = 16'hFFE0;

  function automatic logic [15:0] vec_addr(input logic [3:0] num);
    return VEC_BASE + {11'd0, num, 1'b0};
  endfunction

endpackage

// File: rtl/pu_msp430_irq_prio.sv
// Combinational fixed-priority encoder: NMI first, then highest request index.
// No latency; valid is low when nothing is requesting.
module pu_msp430_irq_prio
  import pu_msp430_irq_pkg::*;
#(
  parameter int IRQ_NR = 14
) (
  input  logic [IRQ_NR-1:0] req,
  input  logic              nmi,
  output logic              valid,
  output logic [3:0]        num
);

  always_comb begin
    valid = 1'b0;
    num   = 4'd0;
    // Ascending scan so the highest set index is the one left standing.
    for (int i = 0; i < IRQ_NR; i++) begin
      if (req[i]) begin
        valid = 1'b1;
        num   = 4'(i);
      end
    end
    if (nmi) begin
      valid = 1'b1;
      num   = NMI_VEC;
    end
  end

endmodule

// File: rtl/pu_msp430_irq_ctrl.sv
// Interrupt scheduler: registered vector request to the CPU, one-cycle accept pulses on ack.
// Request appears one cycle after a source; after int_ack, one ACK cycle blocks re-arbitration.
module pu_msp430_irq_ctrl
  import pu_msp430_irq_pkg::*;
#(
  parameter int IRQ_NR   = 14,
  parameter int WDT_LINE = 10
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic [IRQ_NR-1:0] irq,
  input  logic              wdt_irq,
  input  logic              nmi_pnd,
  input  logic              gie,
  input  logic              dbg_freeze,
  input  logic              int_ack,
  output logic              cpu_req,
  output logic [3:0]        irq_num,
  output logic [IRQ_NR-1:0] irq_acc,
  output logic              wdt_acc,
  output logic              nmi_acc
);

  irq_state_t        state, state_nxt;
  logic [IRQ_NR-1:0] wdt_vec;
  logic [IRQ_NR-1:0] req_eff;
  logic              nmi_eff;
  logic              win_vld;
  logic [3:0]        win_num;

  logic              cpu_req_nxt;
  logic [3:0]        irq_num_nxt;
  logic [IRQ_NR-1:0] irq_acc_nxt;
  logic              wdt_acc_nxt;
  logic              nmi_acc_nxt;

  always_comb begin
    wdt_vec           = '0;
    wdt_vec[WDT_LINE] = wdt_irq;
  end

  assign req_eff = (irq | wdt_vec) & {IRQ_NR{gie & ~dbg_freeze}};
  assign nmi_eff = nmi_pnd & ~dbg_freeze;

  pu_msp430_irq_prio #(
    .IRQ_NR (IRQ_NR)
  ) u_prio (
    .req   (req_eff),
    .nmi   (nmi_eff),
    .valid (win_vld),
    .num   (win_num)
  );

  always_comb begin
    state_nxt   = state;
    cpu_req_nxt = 1'b0;
    irq_num_nxt = irq_num;
    irq_acc_nxt = '0;
    wdt_acc_nxt = 1'b0;
    nmi_acc_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt   = PEND;
          cpu_req_nxt = 1'b1;
          irq_num_nxt = win_num;
        end
      end
      PEND: begin
        if (int_ack) begin
          // The frontend already latched irq_num; service that even if sources moved.
          state_nxt = ACK;
          if (irq_num == NMI_VEC) begin
            nmi_acc_nxt = 1'b1;
          end else if (irq_num == 4'(WDT_LINE) && wdt_irq) begin
            wdt_acc_nxt           = 1'b1;
            irq_acc_nxt[WDT_LINE] = irq[WDT_LINE];
          end else begin
            for (int i = 0; i < IRQ_NR; i++) begin
              if (irq_num == 4'(i)) irq_acc_nxt[i] = 1'b1;
            end
          end
        end else if (win_vld) begin
          cpu_req_nxt = 1'b1;
          irq_num_nxt = win_num;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state   <= IDLE;
      cpu_req <= 1'b0;
      irq_num <= 4'd0;
      irq_acc <= '0;
      wdt_acc <= 1'b0;
      nmi_acc <= 1'b0;
    end else begin
      state   <= state_nxt;
      cpu_req <= cpu_req_nxt;
      irq_num <= irq_num_nxt;
      irq_acc <= irq_acc_nxt;
      wdt_acc <= wdt_acc_nxt;
      nmi_acc <= nmi_acc_nxt;
    end
  end

endmodule
